mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide unit controller for the pipelined MIPS core, sitting in the E stage beside the ALU. It accepts one mult/multu/div/divu/mthi/mtlo/mfhi/mflo operation per cycle, runs multi-cycle multiply (5 cycles) and divide (10 cycles) operations with a countdown sequencer, and owns the architectural HI/LO registers. It exports a busy indication that the hazard unit uses to stall later MD instructions in D.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  E stage holds a valid MD operation this cycle.
- `op`  in  4  operation code, `md_*` encoding.
- `d1`  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- `d2`  in  32  rt operand (divisor / multiplier).
- `busy`  out  1  multi-cycle operation in flight.
- `md_stall`  out  1  `busy | (start & op is mult/multu/div/divu)`; to the hazard unit.
- `hi`  out  32  committed HI.
- `lo`  out  32  committed LO.
- `rd_data`  out  32  `hi` when op==`md_mfhi`, `lo` when op==`md_mflo`, else 0; combinational.

## Operation
- States: IDLE, RUN. Counter `cnt` is 4 bits.
- IDLE, `start`, op ∈ {mult, multu, div, divu}: latch the computed result into shadow `hi_n/lo_n`, load `cnt` = MULT_CYCLES or DIV_CYCLES, go to RUN.
- mult: signed 32×32→64, `{hi_n,lo_n}` = product. multu: unsigned.
- div: `lo_n` = signed quotient (truncated toward zero), `hi_n` = remainder with the sign of the dividend. divu: unsigned.
- Divide by zero (`d2`==0): full DIV_CYCLES of busy; HI/LO are left unchanged at commit.
- RUN: `cnt` decrements each cycle. At the edge where `cnt`==1, commit shadow to HI/LO, then IDLE.
- IDLE, `start`, mthi/mtlo: HI or LO = `d1` at that edge; no busy.
- `start` while in RUN is ignored, whatever the op. The hazard unit guarantees this never happens. The bench still checks that HI/LO and the counter stay untouched.
- mfhi/mflo never change state; they read committed HI/LO only. No forwarding from the shadow registers.
- Undefined op with `start`: no effect.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, shadow=0, `cnt`=0, state IDLE. `md_stall` and `rd_data` follow their combinational definitions.
- `start` sampled at edge E0. `busy`=1 in the cycles following E0 through E0+N, where N is the op's cycle count.
- HI/LO hold new values from the cycle after edge E0+N. `busy`=0 in that same cycle.
- A back-to-back MD op may start in the first cycle with `busy`=0.
- mthi/mtlo: new value visible on `hi`/`lo` in the cycle after the sampling edge.
- `md_stall` rises combinationally in the `start` cycle, so the following D-stage MD instruction stalls at once.
- Reset asserted mid-RUN: immediate return to IDLE, `busy`=0, HI=LO=0. The pending result is discarded.

## Structure
- `md_mult`, `md_multu`, `md_div`, `md_divu`, `md_mthi`, `md_mtlo`, `md_mfhi`, `md_mflo` and `md_none` (4-bit codes) go in the shared `define_file.v` next to the `alu_*` codes. The decoder reuses them.
- Single module, no sub-module. Arithmetic uses the behavioural `*`, `/`, `%` operators (with `$signed` for the signed forms), computed at start; the countdown models latency only.

## Test plan
- mult d1=0xFFFFFFFF, d2=2 → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div d1=0xFFFFFFF9 (−7), d2=2 → `busy` 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1.
- mthi 0x12345678 then divu 5/0 → HI stays 0x12345678, LO unchanged, `busy` still 10 cycles.
- start mult, then at cycle 3 drive `start` with mtlo 0xAAAA and with div → both ignored; mult result commits at cycle 5 unchanged. A div issued the cycle `busy` drops is accepted.
- div in flight, assert `reset` mid-cycle 4 → `busy`, HI, LO go to 0 immediately and nothing commits afterward. mfhi/mflo `rd_data` tracks HI/LO throughout.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg
//   Shared definitions for the multiply/divide unit: the md_* operation
//   codes (also used by the decoder, alongside the alu_* codes), the
//   sequencer state type and small op-classification helpers.
package mdu_ctrl_pkg;

   // Operation codes carried on the 4-bit op field into the E stage.
   // Codes 9..15 are undefined and have no effect on the unit.
   localparam logic [3:0] md_none  = 4'd0;
   localparam logic [3:0] md_mult  = 4'd1;
   localparam logic [3:0] md_multu = 4'd2;
   localparam logic [3:0] md_div   = 4'd3;
   localparam logic [3:0] md_divu  = 4'd4;
   localparam logic [3:0] md_mthi  = 4'd5;
   localparam logic [3:0] md_mtlo  = 4'd6;
   localparam logic [3:0] md_mfhi  = 4'd7;
   localparam logic [3:0] md_mflo  = 4'd8;

   // Countdown sequencer states.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mduState_t;

   // True for the operations that occupy the unit for several cycles.
   function automatic logic isLongOp(input logic [3:0] opCode);
      return (opCode == md_mult) || (opCode == md_multu) ||
             (opCode == md_div)  || (opCode == md_divu);
   endfunction

   // True for the two divide flavours (they use the longer latency).
   function automatic logic isDivOp(input logic [3:0] opCode);
      return (opCode == md_div) || (opCode == md_divu);
   endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// mdu_ctrl
//   Multiply/divide controller for the E stage of the pipelined MIPS core.
//   Accepts one MD operation per cycle, computes mult/multu/div/divu results
//   immediately into shadow registers, then models their latency with a
//   countdown before committing them to the architectural HI/LO registers.
//
//   Parameters
//     MULT_CYCLES  busy cycles for mult/multu (1..15)
//     DIV_CYCLES   busy cycles for div/divu   (1..15)
//   Ports
//     clk       in   rising-edge clock
//     reset     in   asynchronous active-high reset, clears all state
//     start     in   E stage holds a valid MD operation
//     op        in   md_* operation code
//     d1        in   rs operand (dividend / multiplicand / mthi-mtlo source)
//     d2        in   rt operand (divisor / multiplier)
//     busy      out  multi-cycle operation in flight (registered)
//     md_stall  out  busy, or a multi-cycle op being started this cycle
//     hi, lo    out  committed HI / LO
//     rd_data   out  HI for mfhi, LO for mflo, otherwise 0
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] d1,
   input  logic [31:0] d2,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd_data
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   mduState_t   state_q;
   logic [3:0]  cnt_q;
   logic        busy_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] hiShadow_q;
   logic [31:0] loShadow_q;
   logic        divByZero_q;

   logic [31:0]        hiShadow_d;
   logic [31:0]        loShadow_d;
   logic signed [63:0] prodSigned;
   logic [63:0]        prodUnsigned;
   logic               divByZero;
   logic               divOverflow;
   logic signed [31:0] divisorS;
   logic signed [31:0] quotS;
   logic signed [31:0] remS;
   logic [31:0]        divisorU;
   logic [31:0]        quotU;
   logic [31:0]        remU;

   // Behavioural arithmetic for the operation presented this cycle. The
   // divisor is forced to 1 for a zero divisor (result discarded anyway) and
   // for 0x80000000 / -1, whose true quotient does not fit in 32 bits; with a
   // divisor of 1 that case yields the wrapped quotient 0x80000000 and a zero
   // remainder without relying on the host's overflow behaviour.
   always_comb begin
      prodSigned   = $signed({{32{d1[31]}}, d1}) * $signed({{32{d2[31]}}, d2});
      prodUnsigned = {32'd0, d1} * {32'd0, d2};
      divByZero    = (d2 == 32'd0);
      divOverflow  = (d1 == 32'h8000_0000) && (d2 == 32'hFFFF_FFFF);
      divisorS     = (divByZero || divOverflow) ? 32'sd1 : $signed(d2);
      quotS        = $signed(d1) / divisorS;
      remS         = $signed(d1) % divisorS;
      divisorU     = divByZero ? 32'd1 : d2;
      quotU        = d1 / divisorU;
      remU         = d1 % divisorU;
   end

   // Select what the shadow registers would capture if this op starts.
   // A divide by zero leaves the shadow alone since it never commits.
   always_comb begin
      hiShadow_d = hiShadow_q;
      loShadow_d = loShadow_q;
      case (op)
         md_mult:  {hiShadow_d, loShadow_d} = prodSigned;
         md_multu: {hiShadow_d, loShadow_d} = prodUnsigned;
         md_div: begin
            if (!divByZero) begin
               hiShadow_d = remS;
               loShadow_d = quotS;
            end
         end
         md_divu: begin
            if (!divByZero) begin
               hiShadow_d = remU;
               loShadow_d = quotU;
            end
         end
         default: begin
         end
      endcase
   end

   // Sequencer: IDLE accepts new ops (long ops load the countdown, mthi/mtlo
   // write straight through); RUN counts down and commits the shadow on the
   // edge where the count reaches 1. Any start seen in RUN is ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         busy_q      <= 1'b0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         hiShadow_q  <= 32'd0;
         loShadow_q  <= 32'd0;
         divByZero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (isLongOp(op)) begin
                     hiShadow_q  <= hiShadow_d;
                     loShadow_q  <= loShadow_d;
                     divByZero_q <= isDivOp(op) && divByZero;
                     cnt_q       <= isDivOp(op) ? DIV_CNT : MULT_CNT;
                     busy_q      <= 1'b1;
                     state_q     <= RUN;
                  end else if (op == md_mthi) begin
                     hi_q <= d1;
                  end else if (op == md_mtlo) begin
                     lo_q <= d1;
                  end
               end
            end
            RUN: begin
               if (cnt_q == 4'd1) begin
                  if (!divByZero_q) begin
                     hi_q <= hiShadow_q;
                     lo_q <= loShadow_q;
                  end
                  cnt_q   <= 4'd0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // The stall must rise in the start cycle itself, before busy registers.
   always_comb begin
      busy     = busy_q;
      hi       = hi_q;
      lo       = lo_q;
      md_stall = busy_q | (start & isLongOp(op));
      if (op == md_mfhi) begin
         rd_data = hi_q;
      end else if (op == md_mflo) begin
         rd_data = lo_q;
      end else begin
         rd_data = 32'd0;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl
//   Self-checking bench for mdu_ctrl. Directed operations push their
//   hand-computed HI/LO and busy length into a scoreboard; a monitor pops
//   and compares each time busy falls (the commit point).
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] d1;
   logic [31:0] d2;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rd_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } result_t;

   result_t scoreboard[$];

   always #5 clk = ~clk;

   mdu_ctrl #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .d1      (d1),
      .d2      (d2),
      .busy    (busy),
      .md_stall(md_stall),
      .hi      (hi),
      .lo      (lo),
      .rd_data (rd_data)
   );

   // One comparison; reports and counts a failure on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Queue the result a long operation must commit and its busy length.
   task automatic expectResult(input string name, input logic [31:0] expHi,
                               input logic [31:0] expLo, input int cycles);
      result_t r;
      r.name   = name;
      r.hi     = expHi;
      r.lo     = expLo;
      r.cycles = cycles;
      scoreboard.push_back(r);
   endtask

   // Present one operation for one cycle (called just after a falling edge),
   // checking the combinational stall, then return at the next falling edge.
   task automatic applyStimulus(input string name, input logic [3:0] opCode,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic expStall);
      start = 1'b1;
      op    = opCode;
      d1    = a;
      d2    = b;
      #1;
      checkOutput({name, "_stall"}, 32'(md_stall), 32'(expStall));
      @(negedge clk);
      start = 1'b0;
      op    = md_none;
      d1    = 32'd0;
      d2    = 32'd0;
   endtask

   // Wait (bounded) for the first cycle with busy low.
   task automatic waitIdle(input string name);
      int n = 0;
      while (busy === 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   // Read HI and LO back through rd_data; other ops must read as zero.
   task automatic readCheck(input string name, input logic [31:0] expHi,
                            input logic [31:0] expLo);
      op = md_mfhi;
      #1;
      checkOutput({name, "_mfhi"}, rd_data, expHi);
      op = md_mflo;
      #1;
      checkOutput({name, "_mflo"}, rd_data, expLo);
      op = md_none;
      #1;
      checkOutput({name, "_rdNone"}, rd_data, 32'd0);
   endtask

   // Monitor: measure each busy burst and compare against the scoreboard
   // when it ends; a reset discards the burst in progress.
   initial begin
      logic prevBusy;
      int   busyLen;
      prevBusy = 1'b0;
      busyLen  = 0;
      forever begin
         result_t e;
         @(negedge clk);
         if (reset === 1'b1) begin
            prevBusy = 1'b0;
            busyLen  = 0;
         end else begin
            if (busy === 1'b1) begin
               busyLen++;
            end else if (prevBusy) begin
               if (scoreboard.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpectedCommit: got hi=0x%08h lo=0x%08h, expected no commit", hi, lo);
               end else begin
                  e = scoreboard.pop_front();
                  checkOutput({e.name, "_hi"}, hi, e.hi);
                  checkOutput({e.name, "_lo"}, lo, e.lo);
                  checkOutput({e.name, "_busyCycles"}, 32'(busyLen), 32'(e.cycles));
               end
               busyLen = 0;
            end
            prevBusy = (busy === 1'b1);
         end
      end
   end

   // Watchdog against a hung run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = md_mfhi;
      d1    = 32'd0;
      d2    = 32'd0;
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);
      checkOutput("reset_stall", 32'(md_stall), 32'd0);
      checkOutput("reset_rdData", rd_data, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      op    = md_none;
      @(negedge clk);

      // -1 * 2 signed, then unsigned 0xFFFFFFFF * 2
      expectResult("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
      applyStimulus("mult", md_mult, 32'hFFFF_FFFF, 32'd2, 1'b1);
      waitIdle("mult");
      readCheck("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

      expectResult("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
      applyStimulus("multu", md_multu, 32'hFFFF_FFFF, 32'd2, 1'b1);
      waitIdle("multu");

      // -7 / 2 = -3 rem -1; 7 / 2 = 3 rem 1; 7 / -2 = -3 rem 1
      expectResult("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      applyStimulus("div", md_div, 32'hFFFF_FFF9, 32'd2, 1'b1);
      waitIdle("div");
      readCheck("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      expectResult("divu", 32'd1, 32'd3, 10);
      applyStimulus("divu", md_divu, 32'd7, 32'd2, 1'b1);
      waitIdle("divu");

      expectResult("divNegDivisor", 32'd1, 32'hFFFF_FFFD, 10);
      applyStimulus("divNegDivisor", md_div, 32'd7, 32'hFFFF_FFFE, 1'b1);
      waitIdle("divNegDivisor");

      // (-2^31) * (-2^31) = 2^62
      expectResult("multMin", 32'h4000_0000, 32'h0000_0000, 5);
      applyStimulus("multMin", md_mult, 32'h8000_0000, 32'h8000_0000, 1'b1);
      waitIdle("multMin");

      // mthi / mtlo write through with no busy
      applyStimulus("mthi", md_mthi, 32'h1234_5678, 32'd0, 1'b0);
      checkOutput("mthi_hi", hi, 32'h1234_5678);
      checkOutput("mthi_lo", lo, 32'h0000_0000);
      checkOutput("mthi_busy", 32'(busy), 32'd0);
      applyStimulus("mtlo", md_mtlo, 32'hCAFE_F00D, 32'd0, 1'b0);
      checkOutput("mtlo_lo", lo, 32'hCAFE_F00D);

      // divide by zero: full latency, nothing committed
      expectResult("divuByZero", 32'h1234_5678, 32'hCAFE_F00D, 10);
      applyStimulus("divuByZero", md_divu, 32'd5, 32'd0, 1'b1);
      waitIdle("divuByZero");

      // starts during RUN are ignored; 3 * -5 = -15
      expectResult("multIgnore", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
      applyStimulus("multIgnore", md_mult, 32'd3, 32'hFFFF_FFFB, 1'b1);
      @(negedge clk);
      applyStimulus("runMtlo", md_mtlo, 32'h0000_AAAA, 32'd0, 1'b1);
      applyStimulus("runDiv", md_div, 32'd100, 32'd7, 1'b1);
      checkOutput("runIgnore_hi", hi, 32'h1234_5678);
      checkOutput("runIgnore_lo", lo, 32'hCAFE_F00D);
      checkOutput("runIgnore_busy", 32'(busy), 32'd1);
      waitIdle("multIgnore");

      // back-to-back issue in the first non-busy cycle: 100 / 7 = 14 rem 2
      expectResult("b2bDiv", 32'd2, 32'd14, 10);
      applyStimulus("b2bDiv", md_div, 32'd100, 32'd7, 1'b1);
      waitIdle("b2bDiv");
      readCheck("b2bDiv", 32'd2, 32'd14);

      // undefined op has no effect
      applyStimulus("undefOp", 4'hF, 32'hDEAD_BEEF, 32'd1, 1'b0);
      checkOutput("undefOp_hi", hi, 32'd2);
      checkOutput("undefOp_lo", lo, 32'd14);
      checkOutput("undefOp_busy", 32'(busy), 32'd0);

      // reset in the middle of a divide discards it
      applyStimulus("resetDiv", md_div, 32'hFFFF_FFF9, 32'd2, 1'b1);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("midReset_busy", 32'(busy), 32'd0);
      checkOutput("midReset_hi", hi, 32'd0);
      checkOutput("midReset_lo", lo, 32'd0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      repeat (15) @(negedge clk);
      checkOutput("postReset_busy", 32'(busy), 32'd0);
      checkOutput("postReset_hi", hi, 32'd0);
      checkOutput("postReset_lo", lo, 32'd0);
      readCheck("postReset", 32'd0, 32'd0);

      checkOutput("scoreboardEmpty", 32'(scoreboard.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
